// File: rtl/gate_channel_scheduler.sv
// Round-robin scheduler sharing a four-lane gate controller among four requesters.
// Drives select/enable with select held stable across every enable-high window.
module gate_channel_scheduler #(
    parameter int unsigned DWELL_W = 4,
    parameter int unsigned NUM_CH  = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_CH-1:0]  req,
    input  logic [DWELL_W-1:0] dwell,
    output logic [NUM_CH-1:0]  gnt,
    output logic [1:0]         sel,
    output logic               en,
    output logic [NUM_CH-1:0]  done,
    output logic               abort,
    output logic               busy
);

    localparam int unsigned SEL_W = 2;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SETUP   = 2'd1,
        S_ACTIVE  = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    state_t             r_state;
    logic [SEL_W-1:0]   r_ptr;
    logic [SEL_W-1:0]   r_sel;
    logic [DWELL_W-1:0] r_cnt;
    logic [DWELL_W-1:0] r_dwell_q;
    logic [NUM_CH-1:0]  r_gnt;
    logic [NUM_CH-1:0]  r_done;
    logic               r_en;
    logic               r_abort;
    logic               r_busy;

    logic [SEL_W-1:0]   w_win;
    logic [SEL_W-1:0]   w_idx;
    logic               w_found;
    logic [DWELL_W-1:0] w_dwell_eff;
    logic               w_req_cur;
    logic               w_dwell_hit;

    // Rotating-priority search: first requester at or after r_ptr, mod 4.
    always_comb begin
        w_win   = '0;
        w_idx   = '0;
        w_found = 1'b0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            w_idx = r_ptr + SEL_W'(k);
            if (!w_found && req[w_idx]) begin
                w_win   = w_idx;
                w_found = 1'b1;
            end
        end
    end

    // A zero dwell still opens the channel for one cycle.
    assign w_dwell_eff = (dwell == '0) ? DWELL_W'(1) : dwell;
    assign w_req_cur   = req[r_sel];
    assign w_dwell_hit = (r_cnt == r_dwell_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_ptr     <= '0;
            r_sel     <= '0;
            r_cnt     <= '0;
            r_dwell_q <= '0;
            r_gnt     <= '0;
            r_done    <= '0;
            r_en      <= 1'b0;
            r_abort   <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_done  <= '0;
            r_abort <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_state   <= S_SETUP;
                        r_gnt     <= NUM_CH'(1) << w_win;
                        r_sel     <= w_win;
                        r_en      <= 1'b0;
                        r_dwell_q <= w_dwell_eff;
                        r_cnt     <= '0;
                        r_busy    <= 1'b1;
                    end
                end
                S_SETUP: begin
                    // Select has had a full cycle to settle before enable rises.
                    if (!w_req_cur) begin
                        r_state <= S_RELEASE;
                        r_abort <= 1'b1;
                    end else begin
                        r_state <= S_ACTIVE;
                        r_en    <= 1'b1;
                        r_cnt   <= DWELL_W'(1);
                    end
                end
                S_ACTIVE: begin
                    if (!w_req_cur) begin
                        r_state <= S_RELEASE;
                        r_en    <= 1'b0;
                        r_abort <= 1'b1;
                    end else if (w_dwell_hit) begin
                        r_state <= S_RELEASE;
                        r_en    <= 1'b0;
                        r_done  <= r_gnt;
                    end else begin
                        r_cnt <= r_cnt + DWELL_W'(1);
                    end
                end
                S_RELEASE: begin
                    // sel is left untouched so the controller never sees it move while idle.
                    r_state <= S_IDLE;
                    r_gnt   <= '0;
                    r_en    <= 1'b0;
                    r_busy  <= 1'b0;
                    r_ptr   <= r_sel + SEL_W'(1);
                end
                default: begin
                    r_state <= S_IDLE;
                    r_gnt   <= '0;
                    r_en    <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign gnt   = r_gnt;
    assign sel   = r_sel;
    assign en    = r_en;
    assign done  = r_done;
    assign abort = r_abort;
    assign busy  = r_busy;

    // Structural invariants of the controller interface.
    a_gnt_onehot0 : assert property (@(posedge clk) disable iff (rst) $onehot0(r_gnt));
    a_done_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(r_done));
    a_done_abort  : assert property (@(posedge clk) disable iff (rst) !((|r_done) && r_abort));
    a_en_active   : assert property (@(posedge clk) disable iff (rst) r_en |-> (r_state == S_ACTIVE));
    a_cnt_bound   : assert property (@(posedge clk) disable iff (rst) r_cnt <= r_dwell_q);

endmodule

// File: tb/tb_gate_channel_scheduler.sv
// Directed testbench for gate_channel_scheduler: hand-computed cycle-by-cycle
// expectations of {gnt, sel, en, done, abort, busy} for each scenario.
module tb_gate_channel_scheduler;

    localparam int unsigned DWELL_W = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic [3:0]         req;
    logic [DWELL_W-1:0] dwell;
    logic [3:0]         gnt;
    logic [1:0]         sel;
    logic               en;
    logic [3:0]         done;
    logic               abort;
    logic               busy;

    int n_cmp = 0;
    int n_err = 0;
    logic [12:0] exp_v;

    gate_channel_scheduler #(.DWELL_W(DWELL_W), .NUM_CH(4)) dut (
        .clk  (clk),
        .rst  (rst),
        .req  (req),
        .dwell(dwell),
        .gnt  (gnt),
        .sel  (sel),
        .en   (en),
        .done (done),
        .abort(abort),
        .busy (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, summary not reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [12:0] obs();
        return {gnt, sel, en, done, abort, busy};
    endfunction

    function automatic logic [12:0] pk(input logic [3:0] g, input logic [1:0] s, input logic e,
                                        input logic [3:0] d, input logic a, input logic b);
        return {g, s, e, d, a, b};
    endfunction

    task automatic test_reset();
        rst = 1'b1; req = 4'b0000; dwell = 4'd0;
        tick(); tick();
        exp_v = pk(4'b0000, 2'd0, 1'b0, 4'b0000, 1'b0, 1'b0);
        n_cmp++; if (obs() !== exp_v) begin n_err++; $display("FAIL reset_hold got=%b exp=%b", obs(), exp_v); end
        rst = 1'b0;
        tick();
        n_cmp++; if (obs() !== exp_v) begin n_err++; $display("FAIL reset_idle got=%b exp=%b", obs(), exp_v); end
    endtask

    // ch2, dwell 3; dwell changed after SETUP entry must be ignored.
    task automatic test_single_grant();
        req = 4'b0100; dwell = 4'd3;
        tick();
        exp_v = pk(4'b0100, 2'd2, 1'b0, 4'b0000, 1'b0, 1'b1);
        n_cmp++; if (obs() !== exp_v) begin n_err++; $display("FAIL single_setup got=%b exp=%b", obs(), exp_v); end
        dwell = 4'd7;
        for (int c = 0; c < 3; c++) begin
            tick();
            exp_v = pk(4'b0100, 2'd2, 1'b1, 4'b0000, 1'b0, 1'b1);
            n_cmp++; if (obs() !== exp_v) begin n_err++; $display("FAIL single_en%0d got=%b exp=%b", c, obs(), exp_v); end
        end
        tick();
        exp_v = pk(4'b0100, 2'd2, 1'b0, 4'b0100, 1'b0, 1'b1);
        n_cmp++; if (obs() !== exp_v) begin n_err++; $display("FAIL single_done got=%b exp=%b", obs(), exp_v); end
        req = 4'b0000;
        tick();
        exp_v = pk(4'b0000, 2'd2, 1'b0, 4'b0000, 1'b0, 1'b0);
        n_cmp++; if (obs() !== exp_v) begin n_err++; $display("FAIL single_idle got=%b exp=%b", obs(), exp_v); end
        tick();
        n_cmp++; if (obs() !== exp_v) begin n_err++; $display("FAIL single_idle2 got=%b exp=%b", obs(), exp_v); end
    endtask

    // After ch2, ptr=3: req 1101 must pick ch3 (ptr 0 would pick ch0, ptr 2 ch2).
    task automatic test_ptr_advance();
        req = 4'b1101; dwell = 4'd1;
        tick();
        exp_v = pk(4'b1000, 2'd3, 1'b0, 4'b0000, 1'b0, 1'b1);
        n_cmp++; if (obs() !== exp_v) begin n_err++; $display("FAIL ptr_setup got=%b exp=%b", obs(), exp_v); end
        tick();
        exp_v = pk(4'b1000, 2'd3, 1'b1, 4'b0000, 1'b0, 1'b1);
        n_cmp++; if (obs() !== exp_v) begin n_err++; $display("FAIL ptr_en got=%b exp=%b", obs(), exp_v); end
        tick();
        exp_v = pk(4'b1000, 2'd3, 1'b0, 4'b1000, 1'b0, 1'b1);
        n_cmp++; if (obs() !== exp_v) begin n_err++; $display("FAIL ptr_done got=%b exp=%b", obs(), exp_v); end
        req = 4'b0000;
        tick();
        exp_v = pk(4'b0000, 2'd3, 1'b0, 4'b0000, 1'b0, 1'b0);
        n_cmp++; if (obs() !== exp_v) begin n_err++; $display("FAIL ptr_idle got=%b exp=%b", obs(), exp_v); end
    endtask

    // All four requesting, dwell 1: grants 0,1,2,3,0 four cycles apart.
    task automatic test_round_robin();
        logic [3:0] g;
        logic [1:0] s;
        req = 4'b1111; dwell = 4'd1;
        for (int k = 0; k < 5; k++) begin
            s = 2'(k % 4);
            g = 4'b0001 << s;
            tick();
            exp_v = pk(g, s, 1'b0, 4'b0000, 1'b0, 1'b1);
            n_cmp++; if (obs() !== exp_v) begin n_err++; $display("FAIL rr%0d_setup got=%b exp=%b", k, obs(), exp_v); end
            tick();
            exp_v = pk(g, s, 1'b1, 4'b0000, 1'b0, 1'b1);
            n_cmp++; if (obs() !== exp_v) begin n_err++; $display("FAIL rr%0d_en got=%b exp=%b", k, obs(), exp_v); end
            tick();
            exp_v = pk(g, s, 1'b0, g, 1'b0, 1'b1);
            n_cmp++; if (obs() !== exp_v) begin n_err++; $display("FAIL rr%0d_done got=%b exp=%b", k, obs(), exp_v); end
            tick();
            exp_v = pk(4'b0000, s, 1'b0, 4'b0000, 1'b0, 1'b0);
            n_cmp++; if (obs() !== exp_v) begin n_err++; $display("FAIL rr%0d_idle got=%b exp=%b", k, obs(), exp_v); end
        end
        req = 4'b0000;
        tick();
    endtask

    // Grant ch3 (ptr wraps to 0), then 1001 must serve ch0 before ch3.
    task automatic test_wrap();
        req = 4'b1000; dwell = 4'd1;
        tick();
        exp_v = pk(4'b1000, 2'd3, 1'b0, 4'b0000, 1'b0, 1'b1);
        n_cmp++; if (obs() !== exp_v) begin n_err++; $display("FAIL wrap_ch3 got=%b exp=%b", obs(), exp_v); end
        tick(); tick();
        req = 4'b0000;
        tick();
        req = 4'b1001;
        tick();
        exp_v = pk(4'b0001, 2'd0, 1'b0, 4'b0000, 1'b0, 1'b1);
        n_cmp++; if (obs() !== exp_v) begin n_err++; $display("FAIL wrap_first got=%b exp=%b", obs(), exp_v); end
        tick(); tick();
        exp_v = pk(4'b0001, 2'd0, 1'b0, 4'b0001, 1'b0, 1'b1);
        n_cmp++; if (obs() !== exp_v) begin n_err++; $display("FAIL wrap_first_done got=%b exp=%b", obs(), exp_v); end
        req = 4'b1000;
        tick(); tick();
        exp_v = pk(4'b1000, 2'd3, 1'b0, 4'b0000, 1'b0, 1'b1);
        n_cmp++; if (obs() !== exp_v) begin n_err++; $display("FAIL wrap_second got=%b exp=%b", obs(), exp_v); end
        tick(); tick();
        exp_v = pk(4'b1000, 2'd3, 1'b0, 4'b1000, 1'b0, 1'b1);
        n_cmp++; if (obs() !== exp_v) begin n_err++; $display("FAIL wrap_second_done got=%b exp=%b", obs(), exp_v); end
        req = 4'b0000;
        tick();
    endtask

    // dwell 0 behaves as dwell 1.
    task automatic test_dwell_zero();
        req = 4'b0010; dwell = 4'd0;
        tick();
        exp_v = pk(4'b0010, 2'd1, 1'b0, 4'b0000, 1'b0, 1'b1);
        n_cmp++; if (obs() !== exp_v) begin n_err++; $display("FAIL dz_setup got=%b exp=%b", obs(), exp_v); end
        tick();
        exp_v = pk(4'b0010, 2'd1, 1'b1, 4'b0000, 1'b0, 1'b1);
        n_cmp++; if (obs() !== exp_v) begin n_err++; $display("FAIL dz_en got=%b exp=%b", obs(), exp_v); end
        tick();
        exp_v = pk(4'b0010, 2'd1, 1'b0, 4'b0010, 1'b0, 1'b1);
        n_cmp++; if (obs() !== exp_v) begin n_err++; $display("FAIL dz_done got=%b exp=%b", obs(), exp_v); end
        req = 4'b0000;
        tick();
        exp_v = pk(4'b0000, 2'd1, 1'b0, 4'b0000, 1'b0, 1'b0);
        n_cmp++; if (obs() !== exp_v) begin n_err++; $display("FAIL dz_idle got=%b exp=%b", obs(), exp_v); end
    endtask

    // ch2 dwell 8, req withdrawn during the 3rd en-high cycle.
    task automatic test_abort();
        req = 4'b0100; dwell = 4'd8;
        tick();
        exp_v = pk(4'b0100, 2'd2, 1'b0, 4'b0000, 1'b0, 1'b1);
        n_cmp++; if (obs() !== exp_v) begin n_err++; $display("FAIL ab_setup got=%b exp=%b", obs(), exp_v); end
        for (int c = 0; c < 3; c++) begin
            tick();
            exp_v = pk(4'b0100, 2'd2, 1'b1, 4'b0000, 1'b0, 1'b1);
            n_cmp++; if (obs() !== exp_v) begin n_err++; $display("FAIL ab_en%0d got=%b exp=%b", c, obs(), exp_v); end
        end
        req = 4'b0000;
        tick();
        exp_v = pk(4'b0100, 2'd2, 1'b0, 4'b0000, 1'b1, 1'b1);
        n_cmp++; if (obs() !== exp_v) begin n_err++; $display("FAIL ab_release got=%b exp=%b", obs(), exp_v); end
        tick();
        exp_v = pk(4'b0000, 2'd2, 1'b0, 4'b0000, 1'b0, 1'b0);
        n_cmp++; if (obs() !== exp_v) begin n_err++; $display("FAIL ab_idle got=%b exp=%b", obs(), exp_v); end
    endtask

    // ptr=3 picks ch3 from 1001; reset mid-ACTIVE, then restart from ptr 0 picks ch0.
    task automatic test_reset_mid_grant();
        req = 4'b1001; dwell = 4'd5;
        tick();
        exp_v = pk(4'b1000, 2'd3, 1'b0, 4'b0000, 1'b0, 1'b1);
        n_cmp++; if (obs() !== exp_v) begin n_err++; $display("FAIL rm_setup got=%b exp=%b", obs(), exp_v); end
        tick(); tick();
        exp_v = pk(4'b1000, 2'd3, 1'b1, 4'b0000, 1'b0, 1'b1);
        n_cmp++; if (obs() !== exp_v) begin n_err++; $display("FAIL rm_active got=%b exp=%b", obs(), exp_v); end
        rst = 1'b1;
        tick();
        exp_v = pk(4'b0000, 2'd0, 1'b0, 4'b0000, 1'b0, 1'b0);
        n_cmp++; if (obs() !== exp_v) begin n_err++; $display("FAIL rm_reset got=%b exp=%b", obs(), exp_v); end
        rst = 1'b0;
        tick();
        exp_v = pk(4'b0001, 2'd0, 1'b0, 4'b0000, 1'b0, 1'b1);
        n_cmp++; if (obs() !== exp_v) begin n_err++; $display("FAIL rm_restart got=%b exp=%b", obs(), exp_v); end
        req = 4'b0000;
        tick();
        exp_v = pk(4'b0001, 2'd0, 1'b0, 4'b0000, 1'b1, 1'b1);
        n_cmp++; if (obs() !== exp_v) begin n_err++; $display("FAIL rm_setup_abort got=%b exp=%b", obs(), exp_v); end
        tick();
        exp_v = pk(4'b0000, 2'd0, 1'b0, 4'b0000, 1'b0, 1'b0);
        n_cmp++; if (obs() !== exp_v) begin n_err++; $display("FAIL rm_idle got=%b exp=%b", obs(), exp_v); end
    endtask

    // Maximum dwell (15) completes without counter wrap; ptr=1 so ch1 served.
    task automatic test_max_dwell();
        int  n_en;
        bit  seen;
        req = 4'b0010; dwell = 4'd15;
        tick();
        exp_v = pk(4'b0010, 2'd1, 1'b0, 4'b0000, 1'b0, 1'b1);
        n_cmp++; if (obs() !== exp_v) begin n_err++; $display("FAIL max_setup got=%b exp=%b", obs(), exp_v); end
        n_en = 0;
        seen = 1'b0;
        for (int c = 0; c < 40 && !seen; c++) begin
            tick();
            if (en === 1'b1) n_en++;
            if (done !== 4'b0000) seen = 1'b1;
        end
        n_cmp++; if (!seen) begin n_err++; $display("FAIL max_timeout got=no_done exp=done_within_40"); end
        n_cmp++; if (done !== 4'b0010) begin n_err++; $display("FAIL max_done got=%b exp=0010", done); end
        n_cmp++; if (n_en !== 15) begin n_err++; $display("FAIL max_en_cycles got=%0d exp=15", n_en); end
        req = 4'b0000;
        tick();
        exp_v = pk(4'b0000, 2'd1, 1'b0, 4'b0000, 1'b0, 1'b0);
        n_cmp++; if (obs() !== exp_v) begin n_err++; $display("FAIL max_idle got=%b exp=%b", obs(), exp_v); end
    endtask

    initial begin
        rst = 1'b1;
        req = 4'b0000;
        dwell = '0;
        test_reset();
        test_single_grant();
        test_ptr_advance();
        test_round_robin();
        test_wrap();
        test_dwell_zero();
        test_abort();
        test_reset_mid_grant();
        test_max_dwell();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
